// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Optional perf counters (stall_cnt, drop_cnt) enabled by `PIPE_SKID_PERF_EN.
module pipe_stage_skid #(
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
`ifdef PIPE_SKID_PERF_EN
  ,
  parameter int unsigned       CNT_W     = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_SKID_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  drop_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic [DATA_W-1:0] w_main_d;
  logic [DATA_W-1:0] w_skid_d;
  logic              w_in_fire;
  logic              w_out_fire;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_EMPTY;
    else       r_state <= w_next_state;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = ST_EMPTY;
    end else begin
      unique case (r_state)
        ST_EMPTY: if (w_in_fire) w_next_state = ST_ONE;
        ST_ONE: begin
          if (w_in_fire && !w_out_fire)      w_next_state = ST_TWO;
          else if (!w_in_fire && w_out_fire) w_next_state = ST_EMPTY;
        end
        ST_TWO:  if (w_out_fire) w_next_state = ST_ONE;
        default: w_next_state = ST_EMPTY;
      endcase
    end
  end

  // Datapath next values; the skid entry only ever moves into main
  always_comb begin
    w_main_d = r_main;
    w_skid_d = r_skid;
    if (flush) begin
      w_main_d = RESET_VAL;
      w_skid_d = RESET_VAL;
    end else begin
      unique case (r_state)
        ST_EMPTY: if (w_in_fire) w_main_d = in_data;
        ST_ONE: begin
          if (w_in_fire && w_out_fire) w_main_d = in_data;
          else if (w_in_fire)          w_skid_d = in_data;
        end
        ST_TWO:  if (w_out_fire) w_main_d = r_skid;
        default: w_main_d = RESET_VAL;
      endcase
    end
  end

  // Registered outputs: ready/valid follow the next state so no comb path reaches in_ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main      <= RESET_VAL;
      r_skid      <= RESET_VAL;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_main      <= w_main_d;
      r_skid      <= w_skid_d;
      r_in_ready  <= (w_next_state != ST_TWO);
      r_out_valid <= (w_next_state != ST_EMPTY);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;

`ifdef PIPE_SKID_PERF_EN
  localparam int unsigned      SUM_W   = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [1:0]       w_stored;
  logic [SUM_W-1:0] w_drop_sum;

  always_comb begin
    w_stored = 2'd0;
    unique case (r_state)
      ST_ONE:  w_stored = 2'd1;
      ST_TWO:  w_stored = 2'd2;
      default: w_stored = 2'd0;
    endcase
  end

  assign w_drop_sum = SUM_W'(r_drop_cnt) + SUM_W'(w_stored) + SUM_W'(w_in_fire);

  // Saturating counters, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (r_out_valid && !out_ready && (r_stall_cnt != CNT_MAX))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (flush)
        r_drop_cnt <= (w_drop_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : w_drop_sum[CNT_W-1:0];
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign drop_cnt  = r_drop_cnt;
`else
  // Handshake-only build: no counter state.
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus random traffic against a queue model.
// Counter checks are active when built with `PIPE_SKID_PERF_EN.
module tb_pipe_stage_skid;

  localparam int unsigned DATA_W = 32;
  localparam logic [DATA_W-1:0] RV = 32'hA5A5_0000;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
`ifdef PIPE_SKID_PERF_EN
  localparam int unsigned CW = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;
  logic [CW-1:0]     stall_cnt;
  logic [CW-1:0]     drop_cnt;
  int unsigned       m_stall;
  int unsigned       m_drop;
`endif

  int n_checks;
  int n_fail;
  logic [DATA_W-1:0] q[$];

  pipe_stage_skid #(
    .DATA_W    (DATA_W),
    .RESET_VAL (RV)
`ifdef PIPE_SKID_PERF_EN
    ,
    .CNT_W     (CW)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_SKID_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .drop_cnt  (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    q.delete();
`ifdef PIPE_SKID_PERF_EN
    m_stall = 0;
    m_drop  = 0;
`endif
  endfunction

  // Stage behaves as a 2-deep FIFO; ready means fewer than two words held
  function automatic void model_step();
    int unsigned sz;
    bit inf;
    sz  = q.size();
    inf = in_valid && (sz < 2);
`ifdef PIPE_SKID_PERF_EN
    if (sz > 0 && !out_ready && m_stall < CMAX) m_stall++;
    if (flush) m_drop = (m_drop + sz + 32'(inf) > CMAX) ? CMAX : m_drop + sz + 32'(inf);
`endif
    if (flush) begin
      q.delete();
    end else begin
      if (sz > 0 && out_ready) void'(q.pop_front());
      if (inf) q.push_back(in_data);
    end
  endfunction

  task automatic check_outputs();
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
    check("in_ready", 64'(in_ready), 64'(q.size() < 2));
    if (q.size() > 0) check("out_data", 64'(out_data), 64'(q[0]));
`ifdef PIPE_SKID_PERF_EN
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
`endif
  endtask

  // Called at a negedge; drives one cycle and returns at the following negedge
  task automatic cycle(input logic iv, input logic [DATA_W-1:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_clear();

    // Reset values held during and after reset
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_data", 64'(out_data), 64'(RV));
    reset = 1'b0;
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("idle_out_data", 64'(out_data), 64'(RV));

    // Streaming 1..8 with no bubbles
    for (int k = 1; k <= 8; k++) begin
      cycle(1'b1, DATA_W'(k), 1'b1, 1'b0);
      check("stream_data", 64'(out_data), 64'(k));
      check("stream_valid", 64'(out_valid), 64'd1);
      check("stream_ready", 64'(in_ready), 64'd1);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Backpressure fills the skid, then drains in order
    cycle(1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
    cycle(1'b1, 32'hBBBB_0002, 1'b0, 1'b0);
    check("bp_ready_low", 64'(in_ready), 64'd0);
    check("bp_hold_A", 64'(out_data), 64'hAAAA_0001);
    cycle(1'b1, 32'hCCCC_0003, 1'b0, 1'b0);
    check("bp_still_A", 64'(out_data), 64'hAAAA_0001);
    cycle(1'b1, 32'hCCCC_0003, 1'b1, 1'b0);
    check("bp_B_next", 64'(out_data), 64'hBBBB_0002);
    check("bp_ready_back", 64'(in_ready), 64'd1);
    cycle(1'b1, 32'hCCCC_0003, 1'b1, 1'b0);
    check("bp_C_after", 64'(out_data), 64'hCCCC_0003);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("bp_drained", 64'(out_valid), 64'd0);

    // Flush from TWO with in_valid high
    cycle(1'b1, 32'h1111_000A, 1'b0, 1'b0);
    cycle(1'b1, 32'h2222_000B, 1'b0, 1'b0);
    begin
`ifdef PIPE_SKID_PERF_EN
      int unsigned d0;
      d0 = m_drop;
`endif
      cycle(1'b1, 32'h3333_000C, 1'b0, 1'b1);
      check("fl_valid", 64'(out_valid), 64'd0);
      check("fl_ready", 64'(in_ready), 64'd1);
      check("fl_data", 64'(out_data), 64'(RV));
`ifdef PIPE_SKID_PERF_EN
      check("fl_drop2", 64'(drop_cnt), 64'(d0 + 2));
`endif
    end
    for (int k = 0; k < 3; k++) cycle(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle while holding one word
    cycle(1'b1, 32'h5555_0005, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Random traffic against the queue model
    for (int k = 0; k < 400; k++) begin
      cycle(1'($urandom_range(0, 9) < 7), DATA_W'($urandom), 1'($urandom_range(0, 9) < 6),
            1'($urandom_range(0, 19) == 0));
    end

`ifdef PIPE_SKID_PERF_EN
    // Stall counter saturates instead of wrapping
    do_reset();
    cycle(1'b1, 32'h7777_0007, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) cycle(1'b0, '0, 1'b0, 1'b0);
    check("stall_sat", 64'(stall_cnt), 64'd15);
`else
    do_reset();
    cycle(1'b0, '0, 1'b1, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
